mips_fetch_queue: RTL and testbench

- Instruction prefetch stage sitting directly upstream of the pipeline's IF/ID register.
- Owns the fetch PC and issues sequential word fetches to an external instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO, and presents them to the decode stage with valid/ready.
- Flushes the FIFO and restarts fetch when the pipeline redirects on a taken branch, jump or jr.

---
 rtl/mips_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_mips_fetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential word fetches over req/ack,
// and buffers {pc, word} pairs for decode. A pipeline redirect flushes the queue and restarts fetch.
module mips_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_out,
  output logic [31:0]              inst_pc,
  output logic [31:0]              inst_pc_plus4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_next;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_space;
  logic          w_empty;
  logic [31:0]   w_redirect_target;
  logic [31:0]   w_head_data;
  logic [31:0]   w_head_pc;

  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign w_empty           = (r_count == '0);

  // Redirect outranks both queue operations: the acked word and the pop are both squashed.
  assign w_push       = (r_state == S_REQ) && imem_ack && !redirect_valid;
  assign w_pop        = inst_ready && !w_empty && !redirect_valid;
  assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  // A new request is only launched when its word is sure to find a slot.
  assign w_space      = (w_count_next < LP_DEPTH);

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;

    if (redirect_valid) begin
      w_fetch_pc_next = w_redirect_target;
    end else if (w_push) begin
      w_fetch_pc_next = r_fetch_pc + 32'd4;
    end

    case (r_state)
      S_IDLE: begin
        if (redirect_valid || w_space) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_state_next = imem_ack ? S_REQ : S_DRAIN;
        end else if (imem_ack) begin
          w_state_next = w_space ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // The squashed request keeps its address until memory acks it.
    w_addr_next = (w_state_next == S_DRAIN) ? r_addr : w_fetch_pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_addr     <= w_addr_next;
      if (redirect_valid) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= w_count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_pc   = r_mem_pc[r_rd_ptr];

  assign imem_req      = (r_state != S_IDLE);
  assign imem_addr     = r_addr;
  assign inst_valid    = !w_empty;
  assign inst_out      = w_empty ? 32'h0 : w_head_data;
  assign inst_pc       = w_empty ? 32'h0 : w_head_pc;
  assign inst_pc_plus4 = w_empty ? 32'h0 : (w_head_pc + 32'd4);
  assign occupancy     = r_count;

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: directed scenarios followed by randomized traffic, checked
// against an expected instruction stream (sequential words from the latest restart target).
module tb_mips_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk            = 1'b0;
  logic        rst            = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack       = 1'b0;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic [2:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;
  int pops  = 0;

  mips_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the expected stream restarts at RESET_PC or a redirect target and then
  // advances by one word per consumed instruction; nothing may be skipped or repeated.
  logic [31:0] exp_q[$];
  logic [31:0] stream_pc = RESET_PC;
  logic [31:0] exp_pc;
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic        prev_rst  = 1'b1;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    if (!prev_rst && prev_req && !prev_ack) begin
      chk("addr_hold_req", 32'(imem_req), 32'h1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    chk("occ_bound", 32'(32'(occupancy) <= DEPTH), 32'h1);
    chk("valid_vs_occ", 32'(inst_valid), 32'(occupancy != 3'd0));
    if (inst_valid) begin
      chk("pc_plus4", inst_pc_plus4, inst_pc + 32'd4);
    end else begin
      chk("empty_out", inst_out | inst_pc | inst_pc_plus4, 32'h0);
    end

    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      stream_pc = RESET_PC + 32'd4;
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
      stream_pc = (redirect_pc & 32'hFFFF_FFFC) + 32'd4;
    end else if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        exp_q.push_back(stream_pc);
        stream_pc = stream_pc + 32'd4;
      end
      exp_pc = exp_q.pop_front();
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_word", inst_out, mem_word(exp_pc));
      pops++;
    end

    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_rst  = rst;
    prev_addr = imem_addr;
  end

  initial begin
    // Reset then stream at full rate.
    rst = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_outs", inst_out | inst_pc | inst_pc_plus4, 32'h0);
    rst = 1'b0;
    tick();
    chk("s1_req", 32'(imem_req), 32'h1);
    chk("s1_addr", imem_addr, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("stream_addr", imem_addr, 32'(4 * k));
      chk("stream_head", inst_pc, 32'(4 * (k - 1)));
      chk("stream_valid", 32'(inst_valid), 32'h1);
    end

    // Backpressure until the queue fills, then release for one cycle.
    rst = 1'b1; inst_ready = 1'b0; imem_ack = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("full_occ", 32'(occupancy), 32'h4);
    chk("full_req", 32'(imem_req), 32'h0);
    chk("full_addr", imem_addr, 32'h10);
    chk("full_head", inst_pc, 32'h0);
    tick(); tick();
    chk("full_hold_req", 32'(imem_req), 32'h0);
    chk("full_hold_occ", 32'(occupancy), 32'h4);
    inst_ready = 1'b1;
    tick();
    chk("refill_req", 32'(imem_req), 32'h1);
    chk("refill_addr", imem_addr, 32'h10);
    chk("refill_occ", 32'(occupancy), 32'h3);
    inst_ready = 1'b0;
    tick();
    chk("refill_done_req", 32'(imem_req), 32'h0);
    chk("refill_done_occ", 32'(occupancy), 32'h4);
    chk("refill_done_addr", imem_addr, 32'h14);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("one_fetch_only", 32'(imem_req), 32'h0);
    end

    // Redirect while a request is outstanding: drain, then restart at the target.
    rst = 1'b1; inst_ready = 1'b1; imem_ack = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("pre_drain_addr", imem_addr, 32'h8);
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("drain_occ", 32'(occupancy), 32'h0);
    chk("drain_valid", 32'(inst_valid), 32'h0);
    chk("drain_req", 32'(imem_req), 32'h1);
    chk("drain_addr", imem_addr, 32'h8);
    tick(); tick();
    chk("drain_addr_held", imem_addr, 32'h8);
    imem_ack = 1'b1;
    tick();
    chk("post_drain_addr", imem_addr, 32'h40);
    chk("post_drain_occ", 32'(occupancy), 32'h0);
    inst_ready = 1'b0;
    tick();
    chk("post_drain_head", inst_pc, 32'h40);
    chk("post_drain_word", inst_out, mem_word(32'h40));
    chk("post_drain_occ1", 32'(occupancy), 32'h1);
    chk("post_drain_next", imem_addr, 32'h44);

    // Redirect in the same cycle as an ack and a pop.
    imem_ack = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("coinc_occ", 32'(occupancy), 32'h0);
    chk("coinc_valid", 32'(inst_valid), 32'h0);
    chk("coinc_addr", imem_addr, 32'h100);

    // Misaligned target near the top of the address space wraps to zero.
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_occ0", 32'(occupancy), 32'h0);
    tick();
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_head", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", inst_pc_plus4, 32'h0);
    chk("wrap_word", inst_out, mem_word(32'hFFFF_FFFC));
    imem_ack = 1'b0;
    tick();
    chk("wrap_hold", imem_addr, 32'h0);

    // Reset while stalled with three queued entries.
    imem_ack = 1'b1;
    tick(); tick();
    imem_ack = 1'b0;
    tick();
    chk("stall_occ", 32'(occupancy), 32'h3);
    chk("stall_req", 32'(imem_req), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_occ", 32'(occupancy), 32'h0);
    chk("midrst_valid", 32'(inst_valid), 32'h0);
    chk("midrst_addr", imem_addr, RESET_PC);

    // Randomized traffic against the stream model.
    pops = 0;
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
      imem_ack       = ($urandom_range(0, 9) < 6);
      inst_ready     = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    tick();
    chk("progress", 32'(pops > 200), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
